// File: rtl/byte_pair_packer.sv
// Packs a valid/ready byte stream into {first, second} 16-bit words and feeds them
// through a 2-entry FIFO. A packet ending on an odd byte is padded with PAD_BYTE.
module byte_pair_packer #(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_padded,
    output logic [15:0] words_out
);

    localparam int unsigned WORD_W  = 16;
    localparam int unsigned COUNT_W = 2;

    typedef enum logic {
        HALF_EMPTY = 1'b0,
        HALF_FULL  = 1'b1
    } pack_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] data;
        logic              padded;
    } entry_t;

    pack_state_e        state_q, state_d;
    logic [7:0]         high_q, high_d;
    entry_t             mem_q [2];
    entry_t             mem_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [WORD_W-1:0]  words_out_q, words_out_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WORD_W-1:0]  out_data_q, out_data_d;
    logic               out_padded_q, out_padded_d;

    logic               accept;
    logic               consume;
    logic               push;
    entry_t             push_entry;

    // Pack FSM, FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        state_d      = state_q;
        high_d       = high_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        words_out_d  = words_out_q;
        push         = 1'b0;
        push_entry   = '0;
        accept       = in_valid && in_ready_q;
        consume      = (count_q != '0) && out_ready;

        if (accept) begin
            case (state_q)
                HALF_EMPTY: begin
                    if (in_last) begin
                        push       = 1'b1;
                        push_entry = '{data: {in_data, PAD_BYTE}, padded: 1'b1};
                    end else begin
                        high_d  = in_data;
                        state_d = HALF_FULL;
                    end
                end
                HALF_FULL: begin
                    push       = 1'b1;
                    push_entry = '{data: {high_q, in_data}, padded: 1'b0};
                    state_d    = HALF_EMPTY;
                end
                default: state_d = HALF_EMPTY;
            endcase
        end

        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (consume) begin
            rd_ptr_d    = ~rd_ptr_q;
            words_out_d = words_out_q + WORD_W'(1);
        end

        case ({push, consume})
            2'b10:   count_d = count_q + COUNT_W'(1);
            2'b01:   count_d = count_q - COUNT_W'(1);
            default: count_d = count_q;
        endcase

        in_ready_d   = (count_d != COUNT_W'(2));
        out_valid_d  = (count_d != '0);
        out_data_d   = out_valid_d ? mem_d[rd_ptr_d].data   : '0;
        out_padded_d = out_valid_d ? mem_d[rd_ptr_d].padded : 1'b0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= HALF_EMPTY;
            high_q       <= '0;
            mem_q[0]     <= '0;
            mem_q[1]     <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
            words_out_q  <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_padded_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            high_q       <= high_d;
            mem_q[0]     <= mem_d[0];
            mem_q[1]     <= mem_d[1];
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            words_out_q  <= words_out_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_padded_q <= out_padded_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_padded = out_padded_q;
    assign words_out  = words_out_q;

endmodule

// File: tb/tb_byte_pair_packer.sv
// Directed bench for byte_pair_packer: pairing, padding, back-pressure, reset and counter wrap.
module tb_byte_pair_packer;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_padded;
    logic [15:0] words_out;

    int n_checks = 0;
    int n_errors = 0;

    byte_pair_packer #(.PAD_BYTE(8'h00)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_padded (out_padded),
        .words_out  (words_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one byte and hold it until accepted (bounded wait).
    task automatic send(input logic [7:0] d, input logic l);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) chk("send_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h0000);
        chk("rst_out_padded", 32'(out_padded), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_words_out", 32'(words_out), 32'd0);

        // Basic pair
        out_ready = 1'b1;
        send(8'hA5, 1'b0);
        chk("pair_half_no_valid", 32'(out_valid), 32'd0);
        send(8'h3C, 1'b0);
        chk("pair_valid", 32'(out_valid), 32'd1);
        chk("pair_data", 32'(out_data), 32'hA53C);
        chk("pair_padded", 32'(out_padded), 32'd0);
        tick();
        chk("pair_words", 32'(words_out), 32'd1);
        chk("pair_drained", 32'(out_valid), 32'd0);
        tick();
        chk("empty_consume_words", 32'(words_out), 32'd1);

        // Odd packet end, then pairing restarts
        send(8'h12, 1'b1);
        chk("pad_data", 32'(out_data), 32'h1200);
        chk("pad_padded", 32'(out_padded), 32'd1);
        send(8'h34, 1'b0);
        chk("pad_consumed", 32'(out_valid), 32'd0);
        chk("pad_words", 32'(words_out), 32'd2);
        send(8'h56, 1'b0);
        chk("restart_data", 32'(out_data), 32'h3456);
        chk("restart_padded", 32'(out_padded), 32'd0);
        tick();
        chk("restart_words", 32'(words_out), 32'd3);

        // Back-pressure fills the FIFO
        out_ready = 1'b0;
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", 32'(out_data), 32'h0102);
        in_valid = 1'b1; in_data = 8'h05; in_last = 1'b0;
        tick(); tick();
        chk("full_hold_ready", 32'(in_ready), 32'd0);
        chk("full_hold_head", 32'(out_data), 32'h0102);
        out_ready = 1'b1;
        tick();
        chk("bubble_in_ready", 32'(in_ready), 32'd1);
        chk("order_2nd", 32'(out_data), 32'h0304);
        chk("bubble_words", 32'(words_out), 32'd4);
        tick();
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_words", 32'(words_out), 32'd5);
        in_data = 8'h06;
        tick();
        in_valid = 1'b0;
        chk("order_3rd", 32'(out_data), 32'h0506);
        tick();
        chk("order_words", 32'(words_out), 32'd6);

        // Simultaneous push and consume at count 1
        out_ready = 1'b0;
        send(8'hAA, 1'b1);
        chk("sim_head0", 32'(out_data), 32'hAA00);
        out_ready = 1'b1;
        send(8'hBB, 1'b1);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_head1", 32'(out_data), 32'hBB00);
        chk("sim_in_ready", 32'(in_ready), 32'd1);
        chk("sim_words", 32'(words_out), 32'd7);
        tick();
        chk("sim_count1_drained", 32'(out_valid), 32'd0);
        chk("sim_words2", 32'(words_out), 32'd8);

        // Reset mid-operation with a word buffered and a high byte held
        out_ready = 1'b0;
        send(8'h11, 1'b1);
        send(8'hFF, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_words", 32'(words_out), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        send(8'h01, 1'b0);
        chk("mid_rst_no_emit", 32'(out_valid), 32'd0);
        send(8'h02, 1'b0);
        chk("mid_rst_data", 32'(out_data), 32'h0102);
        chk("mid_rst_padded", 32'(out_padded), 32'd0);
        tick();

        // Counter wrap: single-byte packets give one word per cycle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1; in_valid = 1'b1; in_last = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            in_data = 8'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("wrap_pre_words", 32'(words_out), 32'hFFFF);
        chk("wrap_pre_empty", 32'(out_valid), 32'd0);
        send(8'h5A, 1'b1);
        chk("wrap_last_data", 32'(out_data), 32'h5A00);
        tick();
        chk("wrap_words", 32'(words_out), 32'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
